instr_store: RTL
================

INSTR_STORE -- requirements
Module: instr_store

Interface
REQ-001 Parameter DATA_W, default 16, instruction word width in bits.
REQ-002 Parameter DEPTH, default 1024, number of words; any value from 2 to 65536.
REQ-003 Parameter ADDR_W, default 32, width of the fetch and load address ports.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 fetch_req  in  1  fetch request, sampled each cycle.
REQ-007 fetch_addr  in  ADDR_W  word index to fetch.
REQ-008 fetch_valid  out  1  fetch_data/fetch_fault valid this cycle.
REQ-009 fetch_data  out  DATA_W  fetched word.
REQ-010 fetch_fault  out  1  fetch address was >= DEPTH.
REQ-011 load_start  in  1  request to enter program-download mode.
REQ-012 load_valid  in  1  load_addr/load_data/load_last valid.
REQ-013 load_addr  in  ADDR_W  word index to write.
REQ-014 load_data  in  DATA_W  word to write.
REQ-015 load_last  in  1  marks final word of the download.
REQ-016 load_ready  out  1  block accepts a load word this cycle.
REQ-017 load_done  out  1  one-cycle pulse when a download completes.
REQ-018 load_err  out  1  sticky flag: at least one load word was out of range.
REQ-019 busy  out  1  block is in CLEAR or LOAD; fetches are not served.

Function
REQ-020 FSM states SHALL be CLEAR, IDLE and LOAD.
REQ-021 CLEAR: clear counter runs 0..DEPTH-1, writing zero to one word per cycle; after writing word DEPTH-1 the FSM enters IDLE, so CLEAR lasts exactly DEPTH cycles.
REQ-022 IDLE, fetch_req=1 at edge N: fetch_valid=1 after edge N+1, with fetch_data=mem[fetch_addr] (latency 1).
REQ-023 Fetch with fetch_addr >= DEPTH: fetch_valid=1, fetch_fault=1, fetch_data=0; memory is not read.
REQ-024 fetch_valid=0 in any cycle not following an accepted fetch; fetch_data is then 0 and fetch_fault is then 0.
REQ-025 Back-to-back fetches sustain one result per cycle.
REQ-026 fetch_req while busy=1 is ignored: no fetch_valid results from it; the requester retries.
REQ-027 IDLE with load_start=1: FSM enters LOAD at the next edge and load_err clears to 0.
REQ-028 load_start and fetch_req together in IDLE: the fetch is served, then the FSM enters LOAD.
REQ-029 LOAD: load_ready=1; each cycle with load_valid=1 writes load_data to mem[load_addr].
REQ-030 Load word with load_addr >= DEPTH is dropped and sets load_err to 1.
REQ-031 Accepted word with load_last=1: word is written (if in range), load_done pulses for one cycle after the edge, and the FSM returns to IDLE.
REQ-032 load_start while in LOAD or CLEAR is ignored.
REQ-033 Address comparison uses the full ADDR_W bits; the memory index is the low clog2(DEPTH) bits of an in-range address only.
REQ-034 Memory writes occur on the rising edge only; no negative-edge logic.
REQ-035 busy = (state != IDLE), driven from the state register.

Reset
REQ-036 rst_n=0 asynchronously sets: state CLEAR, clear counter 0, fetch_valid 0, fetch_data 0, fetch_fault 0, load_done 0, load_err 0; load_ready 0; busy 1.
REQ-037 Reset during LOAD abandons the download with no load_done; the following CLEAR zeroes all contents.
REQ-038 Memory contents are undefined until CLEAR completes; no initial-block preload.

Structure
REQ-039 Package instr_store_pkg SHALL hold the FSM state enum and the clog2-derived index-width constant function.
REQ-040 One sub-module, instr_store_ram: single-port synchronous RAM (DATA_W x DEPTH, registered read). Single-port is sufficient because reads (IDLE) and writes (CLEAR/LOAD) never coincide.

Verification
REQ-041 Reset release, DEPTH=1024 -> busy=1 for exactly 1024 cycles, then 0; fetch of addr 5 -> fetch_valid=1 next cycle, fetch_data=0.
REQ-042 Load 0x0123@10, 0x4567@11, 0x89AB@12 (load_last on the third word) -> load_done pulse; fetches of 10, 11, 12 back-to-back -> 0x0123, 0x4567, 0x89AB on three consecutive cycles.
REQ-043 Fetch addr 1024 and 0xFFFFFFFF -> fetch_valid=1, fetch_fault=1, fetch_data=0.
REQ-044 Load word at addr 2000 followed by last word at 3 -> load_err=1, mem[3] written; the next load_start clears load_err.
REQ-045 fetch_req held during LOAD -> no fetch_valid until IDLE; load_start with fetch_req in IDLE -> fetch served, busy=1 next cycle.
REQ-046 rst_n asserted mid-LOAD -> outputs reset immediately, no load_done, CLEAR re-runs, fetch of addr 10 returns 0.

Source files
------------

// File: rtl/instr_store_pkg.sv
// Shared types for the instruction store: FSM state encoding
// and the index-width helper used to size the RAM address.
package instr_store_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD
  } state_e;

  function automatic int idx_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_store_ram.sv
// Single-port synchronous RAM with registered read.
// Contents have no reset; the owner clears them after reset.
module instr_store_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int IW     = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_store.sv
// Instruction store: clears memory after reset, serves 1-cycle
// fetches in IDLE and accepts a program download in LOAD.
module instr_store
  import instr_store_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              busy
);

  localparam int IW = idx_w(DEPTH);
  // Compare wide enough that DEPTH itself never truncates.
  localparam int CW = (ADDR_W > 32) ? ADDR_W + 1 : 33;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_e state_q, state_d;
  logic [IW-1:0] clr_q, clr_d;
  logic fv_q, ff_q, done_q, err_q;

  logic              fetch_ok, load_ok;
  logic              acc_fetch, acc_load;
  logic              ram_we, ram_re;
  logic [IW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign fetch_ok  = CW'(fetch_addr) < DEPTH_C;
  assign load_ok   = CW'(load_addr) < DEPTH_C;
  assign acc_fetch = (state_q == ST_IDLE) && fetch_req;
  assign acc_load  = (state_q == ST_LOAD) && load_valid;

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_q;
        clr_d    = clr_q + 1'b1;
        if (clr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          clr_d   = '0;
        end
      end
      ST_IDLE: begin
        ram_re   = fetch_req && fetch_ok;
        ram_addr = fetch_addr[IW-1:0];
        if (load_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ram_we    = load_valid && load_ok;
        ram_addr  = load_addr[IW-1:0];
        ram_wdata = load_data;
        if (load_valid && load_last) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      fv_q    <= acc_fetch;
      ff_q    <= acc_fetch && !fetch_ok;
      done_q  <= acc_load && load_last;
      if ((state_q == ST_IDLE) && load_start) err_q <= 1'b0;
      else if (acc_load && !load_ok) err_q <= 1'b1;
    end
  end

  instr_store_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // RAM output register holds stale data; gate it to the valid slot.
  assign fetch_data  = (fv_q && !ff_q) ? ram_rdata : '0;
  assign fetch_valid = fv_q;
  assign fetch_fault = ff_q;
  assign load_ready  = (state_q == ST_LOAD);
  assign load_done   = done_q;
  assign load_err    = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
